// File: rtl/halt_dump_unit.sv
// End-of-run dump source: counts run cycles until the CPU halts, then streams the
// cycle count followed by every architectural register over a valid/ready port.
module halt_dump_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_halted,
  output logic [IDX_W-1:0] rf_rd_addr,
  input  logic [XLEN-1:0]  rf_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_is_cycle,
  output logic [XLEN-1:0]  cycle_count,
  output logic             dump_done
);

  typedef enum logic [2:0] {
    RUN,
    SEND_CYC,
    LOAD,
    SEND_REG,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;

  // idx only changes on a handshake, so it is already stable for the whole LOAD cycle.
  assign rf_rd_addr = idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      cycle_count  <= '0;
      idx          <= '0;
      out_valid    <= 1'b0;
      out_is_cycle <= 1'b0;
      dump_done    <= 1'b0;
      out_data     <= '0;
      out_index    <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (is_halted) begin
            state        <= SEND_CYC;
            out_valid    <= 1'b1;
            out_is_cycle <= 1'b1;
            out_data     <= cycle_count;
            out_index    <= '0;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + XLEN'(1);
          end
        end
        SEND_CYC: begin
          if (out_ready) begin
            state        <= LOAD;
            out_valid    <= 1'b0;
            out_is_cycle <= 1'b0;
            idx          <= '0;
          end
        end
        LOAD: begin
          state     <= SEND_REG;
          out_data  <= rf_rd_data;
          out_index <= idx;
          out_valid <= 1'b1;
        end
        SEND_REG: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_W'(NUM_REGS - 1)) begin
              state     <= DONE;
              dump_done <= 1'b1;
            end else begin
              state <= LOAD;
              idx   <= idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_dump_unit.sv
// Directed bench for halt_dump_unit: full dumps, backpressure, halt drop, mid-dump
// reset, and counter saturation on a narrow second instance.
module tb_halt_dump_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        is_halted = 1'b0;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_is_cycle;
  logic [31:0] cycle_count;
  logic        dump_done;

  logic        s_reset = 1'b0;
  logic        s_halt = 1'b0;
  logic [1:0]  s_rf_rd_addr;
  logic [3:0]  s_rf_rd_data;
  logic        s_out_valid;
  logic [3:0]  s_out_data;
  logic [1:0]  s_out_index;
  logic        s_out_is_cycle;
  logic [3:0]  s_cycle_count;
  logic        s_dump_done;

  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;

  halt_dump_unit #(.XLEN(32), .NUM_REGS(32), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .is_halted(is_halted),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_is_cycle(out_is_cycle),
    .cycle_count(cycle_count), .dump_done(dump_done)
  );

  // Narrow counter so saturation is reachable in a handful of cycles.
  halt_dump_unit #(.XLEN(4), .NUM_REGS(4), .IDX_W(2)) sat_dut (
    .clk(clk), .reset(s_reset), .is_halted(s_halt),
    .rf_rd_addr(s_rf_rd_addr), .rf_rd_data(s_rf_rd_data),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .out_index(s_out_index), .out_is_cycle(s_out_is_cycle),
    .cycle_count(s_cycle_count), .dump_done(s_dump_done)
  );

  assign rf_rd_data   = rf[rf_rd_addr];
  assign s_rf_rd_data = {2'b00, s_rf_rd_addr};

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input int i);
    return {8'hA5, 8'(i), 16'(i * 257 + 3)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    is_halted = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic get_word(input string tag, input logic [31:0] d, input int i, input logic c);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, out_data, d);
    check_eq({tag, "_index"}, 32'(out_index), 32'(i));
    check_eq({tag, "_is_cycle"}, 32'(out_is_cycle), 32'(c));
    out_ready = 1'b1;
    step();
  endtask

  task automatic dump_regs(input int first);
    for (int i = first; i < 32; i++) get_word("reg", rf_val(i), i, 1'b0);
    check_eq("dump_done", 32'(dump_done), 32'd1);
    check_eq("valid_after_done", 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = rf_val(i);

    // Reset state
    step();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", cycle_count, 32'd0);
    check_eq("rst_done", 32'(dump_done), 32'd0);
    check_eq("rst_data", out_data, 32'd0);
    check_eq("rst_addr", 32'(rf_rd_addr), 32'd0);
    check_eq("rst_is_cycle", 32'(out_is_cycle), 32'd0);

    // 1: 100 run edges, ready tied high, full dump
    do_reset();
    out_ready = 1'b1;
    repeat (100) step();
    check_eq("t1_count", cycle_count, 32'd100);
    is_halted = 1'b1;
    step();
    get_word("t1_cyc", 32'd100, 0, 1'b1);
    dump_regs(0);
    check_eq("t1_count_frozen", cycle_count, 32'd100);
    repeat (3) step();
    check_eq("t1_done_sticky", 32'(dump_done), 32'd1);

    // 2: halted at the first edge after release
    do_reset();
    is_halted = 1'b1;
    out_ready = 1'b1;
    step();
    get_word("t2_cyc", 32'd0, 0, 1'b1);
    dump_regs(0);

    // 3: backpressure on index 7
    do_reset();
    repeat (7) step();
    is_halted = 1'b1;
    step();
    get_word("t3_cyc", 32'd7, 0, 1'b1);
    for (int i = 0; i < 7; i++) get_word("t3_reg", rf_val(i), i, 1'b0);
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check_eq("t3_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t3_hold_index", 32'(out_index), 32'd7);
      check_eq("t3_hold_data", out_data, rf_val(7));
      step();
    end
    out_ready = 1'b1;
    check_eq("t3_still7", 32'(out_index), 32'd7);
    step();
    check_eq("t3_load_gap", 32'(out_valid), 32'd0);
    step();
    check_eq("t3_idx8", 32'(out_index), 32'd8);
    dump_regs(8);

    // 4: drop is_halted after capture
    do_reset();
    out_ready = 1'b1;
    repeat (20) step();
    is_halted = 1'b1;
    step();
    is_halted = 1'b0;
    get_word("t4_cyc", 32'd20, 0, 1'b1);
    dump_regs(0);
    check_eq("t4_count_frozen", cycle_count, 32'd20);

    // 5: async reset while index 12 is on the port
    do_reset();
    out_ready = 1'b1;
    repeat (3) step();
    is_halted = 1'b1;
    step();
    get_word("t5_cyc", 32'd3, 0, 1'b1);
    for (int i = 0; i < 12; i++) get_word("t5_reg", rf_val(i), i, 1'b0);
    out_ready = 1'b0;
    step();
    check_eq("t5_at12", 32'(out_index), 32'd12);
    check_eq("t5_valid12", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_count", cycle_count, 32'd0);
    is_halted = 1'b0;
    out_ready = 1'b1;
    step();
    reset = 1'b1;
    repeat (5) step();
    is_halted = 1'b1;
    step();
    get_word("t5_recyc", 32'd5, 0, 1'b1);
    get_word("t5_reg0", rf_val(0), 0, 1'b0);

    // 6: saturation on the 4-bit instance (14 = max-1, then pinned at max)
    s_reset = 1'b1;
    repeat (14) step();
    check_eq("t6_max_m1", 32'(s_cycle_count), 32'hE);
    step();
    check_eq("t6_max", 32'(s_cycle_count), 32'hF);
    repeat (4) step();
    check_eq("t6_saturated", 32'(s_cycle_count), 32'hF);
    s_halt = 1'b1;
    step();
    check_eq("t6_cyc_word", 32'(s_out_data), 32'hF);
    check_eq("t6_cyc_flag", 32'(s_out_is_cycle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
